// File: rtl/pipe_result_buf_pkg.sv
// Shared defaults, width helpers and entry type for the adder result buffer.
package pipe_result_buf_pkg;

    localparam int DW_DEFAULT    = 32;
    localparam int DEPTH_DEFAULT = 8;
    localparam int SKID_DEFAULT  = 4;

    typedef logic [DW_DEFAULT-1:0] res_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_result_buf_if.sv
// Adder-to-buffer-to-consumer signal bundle; master is the adder/consumer side.
interface pipe_result_buf_if #(
    parameter int DW    = 32,
    parameter int DEPTH = 8
);
    logic                         flush;
    logic                         vld_i;
    logic [DW-1:0]                result_i;
    logic                         stall_o;
    logic [DW-1:0]                out_data;
    logic                         out_valid;
    logic                         out_ready;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic                         ovf;

    modport master (
        output flush, vld_i, result_i, out_ready,
        input  stall_o, out_data, out_valid, count, ovf
    );

    modport slave (
        input  flush, vld_i, result_i, out_ready,
        output stall_o, out_data, out_valid, count, ovf
    );
endinterface

// File: rtl/pipe_result_buf_mem.sv
// Result storage array: one synchronous write port, one combinational read port.
// Latency: write visible on the read port the cycle after the write edge; no backpressure.
module pipe_result_buf_mem
    import pipe_result_buf_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [ptr_w(DEPTH)-1:0]  i_waddr,
    input  logic [DW-1:0]            i_wdata,
    input  logic [ptr_w(DEPTH)-1:0]  i_raddr,
    output logic [DW-1:0]            o_rdata
);
    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/pipe_result_buf.sv
// Circular result FIFO behind the pipelined adder; optional pop accumulator via PIPE_RESULT_BUF_ACC_EN.
// Latency: vld_i to out_valid 1 cycle, no bypass; 1 push + 1 pop per cycle.
// Backpressure: registered stall_o at count >= DEPTH-SKID; overflowing pushes drop and set sticky ovf.
module pipe_result_buf
    import pipe_result_buf_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int SKID  = SKID_DEFAULT
) (
    input  logic                 clk,
    input  logic                 resetn,
    pipe_result_buf_if.slave     bus
`ifdef PIPE_RESULT_BUF_ACC_EN
    ,
    output logic [DW+7:0]        acc
`endif
);
    localparam int AW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - SKID);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_stall;
    logic          r_ovf;

    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_count_nxt;
    logic [DW-1:0] w_rdata;

    // A pop frees a slot in the same cycle, so a full buffer still accepts a push.
    assign w_pop  = (r_count != '0) & bus.out_ready;
    assign w_push = bus.vld_i & ((r_count != FULL_CNT) | w_pop);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)
            w_count_nxt = r_count + CW'(1);
        else if (!w_push && w_pop)
            w_count_nxt = r_count - CW'(1);
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_stall  <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_stall  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_nxt;
            r_stall <= (w_count_nxt >= STALL_CNT);
            if (bus.vld_i && !w_push)
                r_ovf <= 1'b1;
        end
    end

    pipe_result_buf_mem #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push & ~bus.flush),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.result_i),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    assign bus.out_data  = w_rdata;
    assign bus.out_valid = (r_count != '0);
    assign bus.count     = r_count;
    assign bus.stall_o   = r_stall;
    assign bus.ovf       = r_ovf;

`ifdef PIPE_RESULT_BUF_ACC_EN
    logic [DW+7:0] r_acc;

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn)
            r_acc <= '0;
        else if (bus.flush)
            r_acc <= '0;
        else if (w_pop)
            r_acc <= r_acc + {8'd0, w_rdata};
    end

    assign acc = r_acc;
`endif
endmodule

// File: tb/tb_pipe_result_buf.sv
// Directed and randomized checks of pipe_result_buf against a queue-based model.
module tb_pipe_result_buf;
    import pipe_result_buf_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int SKID  = 4;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    pipe_result_buf_if #(.DW(DW), .DEPTH(DEPTH)) bus();

`ifdef PIPE_RESULT_BUF_ACC_EN
    logic [DW+7:0] acc;
`endif

    pipe_result_buf #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .SKID  (SKID)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
`ifdef PIPE_RESULT_BUF_ACC_EN
        ,
        .acc    (acc)
`endif
    );

    int checks = 0;
    int passed = 0;

    res_t          mq[$];
    logic          m_ovf;
    logic          m_stall;
    logic [DW+7:0] m_acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_clear();
        mq.delete();
        m_ovf   = 1'b0;
        m_stall = 1'b0;
        m_acc   = '0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":count"}, 64'(bus.count), 64'(mq.size()));
        chk({tag, ":valid"}, 64'(bus.out_valid), 64'(mq.size() != 0));
        chk({tag, ":stall"}, 64'(bus.stall_o), 64'(m_stall));
        chk({tag, ":ovf"}, 64'(bus.ovf), 64'(m_ovf));
        if (mq.size() != 0)
            chk({tag, ":data"}, 64'(bus.out_data), 64'(mq[0]));
`ifdef PIPE_RESULT_BUF_ACC_EN
        chk({tag, ":acc"}, 64'(acc), 64'(m_acc));
`endif
    endtask

    // One clock: drive inputs, take the edge, advance the model, check just after the edge.
    task automatic cyc(input string tag, input bit v, input res_t d, input bit r, input bit f);
        bit full;
        bus.vld_i     = v;
        bus.result_i  = d;
        bus.out_ready = r;
        bus.flush     = f;
        @(posedge clk);
        if (f) begin
            model_clear();
        end else begin
            full = (mq.size() == DEPTH);
            if (r && mq.size() != 0) begin
                m_acc = m_acc + {8'd0, mq[0]};
                void'(mq.pop_front());
                full = 1'b0;
            end
            if (v) begin
                if (full) m_ovf = 1'b1;
                else      mq.push_back(d);
            end
            m_stall = (mq.size() >= DEPTH - SKID);
        end
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset mid-cycle: contents must vanish before any clock edge.
    task automatic mid_reset(input string tag);
        #3;
        resetn = 1'b1;
        #1;
        model_clear();
        check_all({tag, ":async"});
        @(posedge clk);
        #1;
        check_all({tag, ":held"});
        resetn = 1'b0;
    endtask

    initial begin
        resetn        = 1'b1;
        bus.flush     = 1'b0;
        bus.vld_i     = 1'b0;
        bus.result_i  = '0;
        bus.out_ready = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        resetn = 1'b0;

        // Streaming with a ready consumer
        for (int i = 1; i <= 5; i++) cyc("stream", 1'b1, res_t'(i), 1'b1, 1'b0);
        cyc("stream_drain", 1'b0, '0, 1'b1, 1'b0);

        // Fill to threshold, then full, then overflow
        for (int i = 0; i < 4; i++) cyc("fill4", 1'b1, res_t'(32'h20 + i), 1'b0, 1'b0);
        chk("stall_at_thresh", 64'(bus.stall_o), 64'd1);
        for (int i = 4; i < 8; i++) cyc("fill8", 1'b1, res_t'(32'h20 + i), 1'b0, 1'b0);
        chk("full_count", 64'(bus.count), 64'd8);
        chk("full_no_ovf", 64'(bus.ovf), 64'd0);
        cyc("overflow", 1'b1, res_t'(32'hBAD), 1'b0, 1'b0);
        chk("ovf_set", 64'(bus.ovf), 64'd1);
        chk("ovf_count", 64'(bus.count), 64'd8);

        // Full with simultaneous push and pop
        cyc("flush1", 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) cyc("refill", 1'b1, res_t'(32'h10 + i), 1'b0, 1'b0);
        cyc("full_pp", 1'b1, res_t'(32'hAA), 1'b1, 1'b0);
        chk("full_pp_count", 64'(bus.count), 64'd8);
        chk("full_pp_ovf", 64'(bus.ovf), 64'd0);
        for (int i = 0; i < 8; i++) cyc("full_drain", 1'b0, '0, 1'b1, 1'b0);
        chk("full_drain_empty", 64'(bus.out_valid), 64'd0);

        // Wrap-around with toggling ready
        for (int i = 0; i < 20; i++) cyc("wrap", 1'b1, res_t'(32'h100 + i), (i % 2) == 0, 1'b0);
        for (int i = 0; i < 10; i++) cyc("wrap_drain", 1'b0, '0, 1'b1, 1'b0);

        // Flush beats a concurrent push and clears ovf
        cyc("flush2", 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) cyc("pre_flush", 1'b1, res_t'(32'h300 + i), 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cyc("pre_flush_pop", 1'b0, '0, 1'b1, 1'b0);
        chk("six_count", 64'(bus.count), 64'd6);
        chk("six_ovf", 64'(bus.ovf), 64'd1);
        cyc("flush_vld", 1'b1, res_t'(32'h55), 1'b0, 1'b1);
        chk("flush_count", 64'(bus.count), 64'd0);
        chk("flush_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_ovf", 64'(bus.ovf), 64'd0);
        chk("flush_stall", 64'(bus.stall_o), 64'd0);

`ifdef PIPE_RESULT_BUF_ACC_EN
        cyc("acc_a", 1'b1, res_t'(32'hFFFF_FFFF), 1'b1, 1'b0);
        cyc("acc_b", 1'b1, res_t'(32'hFFFF_FFFF), 1'b1, 1'b0);
        cyc("acc_c", 1'b1, res_t'(32'h2), 1'b1, 1'b0);
        cyc("acc_d", 1'b0, '0, 1'b1, 1'b0);
        chk("acc_sum", 64'(acc), 64'h02_0000_0000);
        for (int i = 0; i < 3; i++) cyc("acc_fill", 1'b1, res_t'(i + 7), 1'b0, 1'b0);
        mid_reset("acc_rst");
        chk("acc_rst_acc", 64'(acc), 64'd0);
`endif

        // Random traffic, with an asynchronous reset midway
        for (int i = 0; i < 400; i++) begin
            bit   v, r, f;
            res_t d;
            if (i == 200) begin
                for (int k = 0; k < 5; k++) cyc("pre_rst", 1'b1, res_t'($urandom), 1'b0, 1'b0);
                mid_reset("rand_rst");
                cyc("post_rst", 1'b1, res_t'(32'hC0DE), 1'b0, 1'b0);
            end
            v = bus.stall_o ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 2) != 0);
            f = ($urandom_range(0, 39) == 0);
            d = res_t'($urandom);
            cyc("rand", v, d, r, f);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
